// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave keypad front end and countdown.
//   state_e  : controller FSM states
//   key_e    : keypad strobe after priority resolution
//   bcd_t    : one BCD digit, shared with the countdown counters
//   dcount_t : number of digits entered so far
package microwave_pkg;

   typedef logic [3:0] bcd_t;
   typedef logic [1:0] dcount_t;

   localparam bcd_t    MAX_UNI    = 4'd9;
   localparam bcd_t    MAX_DEZ    = 4'd5;
   localparam bcd_t    MAX_MIN    = 4'd9;
   localparam dcount_t MAX_DIGITS = 2'd3;

   typedef enum logic [2:0] {
      StIdle,
      StEntry,
      StLoad,
      StRun,
      StPause,
      StDone
   } state_e;

   // Only one key is acted on per cycle: clear > start > stop > digit.
   typedef enum logic [2:0] {
      KeyNone,
      KeyDigit,
      KeyStop,
      KeyStart,
      KeyClear
   } key_e;

endpackage

// File: rtl/bcd_entry_reg.sv
// Three-digit M:SS preset shift register with digit counter and
// accept/reject logic.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   clr_i             : clear preset to 0:00 and count to 0 (highest priority)
//   quick_i           : load quick-start preset 0:QUICK_DS:0
//   shift_i           : shift digit_i in (caller only asserts when !reject_o)
//   digit_i           : keypad BCD value
//   uni_sec_o, dez_sec_o, min_o : current preset
//   preset_nonzero_o  : preset differs from 0:00
//   reject_o          : digit_i would be rejected right now
module bcd_entry_reg
   import microwave_pkg::*;
#(
   parameter int unsigned QUICK_DS = 3
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic quick_i,
   input  logic shift_i,
   input  bcd_t digit_i,
   output bcd_t uni_sec_o,
   output bcd_t dez_sec_o,
   output bcd_t min_o,
   output logic preset_nonzero_o,
   output logic reject_o
);

   bcd_t    uni_q, uni_d;
   bcd_t    dez_q, dez_d;
   bcd_t    min_q, min_d;
   dcount_t cnt_q, cnt_d;

   // A units digit above 5 would land in the tens-of-seconds slot on the
   // next shift, which is not a legal seconds value.
   always_comb begin
      reject_o = (digit_i > MAX_UNI) || (cnt_q >= MAX_DIGITS) || (uni_q > MAX_DEZ);
   end

   always_comb begin
      uni_d = uni_q;
      dez_d = dez_q;
      min_d = min_q;
      cnt_d = cnt_q;
      if (clr_i) begin
         uni_d = '0;
         dez_d = '0;
         min_d = '0;
         cnt_d = '0;
      end else if (quick_i) begin
         uni_d = '0;
         dez_d = bcd_t'(QUICK_DS);
         min_d = '0;
         cnt_d = 2'd2;
      end else if (shift_i) begin
         min_d = dez_q;
         dez_d = uni_q;
         uni_d = digit_i;
         cnt_d = cnt_q + 2'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         uni_q <= '0;
         dez_q <= '0;
         min_q <= '0;
         cnt_q <= '0;
      end else begin
         uni_q <= uni_d;
         dez_q <= dez_d;
         min_q <= min_d;
         cnt_q <= cnt_d;
      end
   end

   assign uni_sec_o        = uni_q;
   assign dez_sec_o        = dez_q;
   assign min_o            = min_q;
   assign preset_nonzero_o = |{uni_q, dez_q, min_q};

endmodule

// File: rtl/microwave_keypad_ctrl.sv
// Keypad front end for the microwave countdown timer. Assembles a M:SS
// preset from BCD keys, then drives the countdown's load/enable and reports
// end of cook. All outputs are registered.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   digit_i, digit_valid_i : keypad digit and its one-cycle strobe
//   start_i, stop_i, clear_i : key strobes
//   zero_i              : countdown reports 0:00
//   uni_sec_o, dez_sec_o, min_o : preset to the countdown
//   load_o              : one-cycle parallel-load pulse
//   enable_o            : countdown enable
//   done_o              : end-of-cook indication, DONE_CYCLES long
//   err_o               : one-cycle pulse for a rejected key
module microwave_keypad_ctrl
   import microwave_pkg::*;
#(
   parameter int unsigned DONE_CYCLES = 3,
   parameter int unsigned QUICK_DS    = 3
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [3:0] digit_i,
   input  logic       digit_valid_i,
   input  logic       start_i,
   input  logic       stop_i,
   input  logic       clear_i,
   input  logic       zero_i,
   output logic [3:0] uni_sec_o,
   output logic [3:0] dez_sec_o,
   output logic [3:0] min_o,
   output logic       load_o,
   output logic       enable_o,
   output logic       done_o,
   output logic       err_o
);

   localparam int unsigned DoneW = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;

   state_e           state_q, state_d;
   key_e             key;
   logic [DoneW-1:0] done_cnt_q, done_cnt_d;
   logic             first_q, first_d;
   logic             load_q, enable_q, done_q, err_q;
   logic             err_d;

   logic entry_clr, entry_quick, entry_shift;
   logic preset_nonzero, reject;

   bcd_entry_reg #(
      .QUICK_DS (QUICK_DS)
   ) u_entry (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .clr_i            (entry_clr),
      .quick_i          (entry_quick),
      .shift_i          (entry_shift),
      .digit_i          (digit_i),
      .uni_sec_o        (uni_sec_o),
      .dez_sec_o        (dez_sec_o),
      .min_o            (min_o),
      .preset_nonzero_o (preset_nonzero),
      .reject_o         (reject)
   );

   always_comb begin
      key = KeyNone;
      if (clear_i)            key = KeyClear;
      else if (start_i)       key = KeyStart;
      else if (stop_i)        key = KeyStop;
      else if (digit_valid_i) key = KeyDigit;
   end

   always_comb begin
      state_d     = state_q;
      done_cnt_d  = done_cnt_q;
      err_d       = 1'b0;
      entry_quick = 1'b0;
      entry_shift = 1'b0;
      // The counter needs one cycle after the load to show the preset, so a
      // stale zero from the previous cook must not end the new one.
      first_d     = (state_q == StLoad);

      case (state_q)
         StIdle, StEntry: begin
            case (key)
               KeyClear: state_d = StIdle;
               KeyStart: begin
                  if (state_q == StIdle) begin
                     entry_quick = 1'b1;
                     state_d     = StLoad;
                  end else if (preset_nonzero) begin
                     state_d = StLoad;
                  end else begin
                     err_d = 1'b1;
                  end
               end
               KeyDigit: begin
                  if (reject) begin
                     err_d = 1'b1;
                  end else begin
                     entry_shift = 1'b1;
                     state_d     = StEntry;
                  end
               end
               default: ;
            endcase
         end
         StLoad: begin
            if (key == KeyClear) begin
               state_d = StIdle;
            end else begin
               state_d = StRun;
               if (key == KeyDigit) err_d = 1'b1;
            end
         end
         StRun: begin
            if (key == KeyClear) begin
               state_d = StIdle;
            end else if (key == KeyStop) begin
               state_d = StPause;
            end else begin
               if (key == KeyDigit) err_d = 1'b1;
               if (zero_i && !first_q) begin
                  state_d    = StDone;
                  done_cnt_d = DoneW'(DONE_CYCLES - 1);
               end
            end
         end
         StPause: begin
            case (key)
               KeyClear: state_d = StIdle;
               KeyStart: state_d = StRun;
               KeyDigit: err_d   = 1'b1;
               default: ;
            endcase
         end
         StDone: begin
            if (key == KeyClear) begin
               state_d = StIdle;
            end else if (done_cnt_q == '0) begin
               state_d = StIdle;
            end else begin
               done_cnt_d = done_cnt_q - 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      // Sitting in or entering IDLE always means an empty 0:00 preset.
      entry_clr = (state_d == StIdle);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         done_cnt_q <= '0;
         first_q    <= 1'b0;
         load_q     <= 1'b0;
         enable_q   <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         done_cnt_q <= done_cnt_d;
         first_q    <= first_d;
         load_q     <= (state_d == StLoad);
         enable_q   <= (state_d == StRun);
         done_q     <= (state_d == StDone);
         err_q      <= err_d;
      end
   end

   assign load_o   = load_q;
   assign enable_o = enable_q;
   assign done_o   = done_q;
   assign err_o    = err_q;

endmodule
